// File: rtl/uart_mm_master.sv
// Avalon-MM master driven by UART command bytes: write (opcode + data) or
// read (opcode), with read results and timeout errors returned as one tx byte.
module uart_mm_master #(
    parameter int                ADDR_W       = 4,
    parameter int                DATA_W       = 8,
    parameter int                READ_LATENCY = 1,
    parameter int                WAIT_TIMEOUT = 255,
    parameter logic [DATA_W-1:0] ERR_BYTE     = 8'hEE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic              avm_read_o,
    output logic              avm_write_o,
    output logic [DATA_W-1:0] avm_writedata_o,
    input  logic [DATA_W-1:0] avm_readdata_i,
    input  logic              avm_waitrequest_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_DATA, S_WR, S_RD, S_RD_LAT, S_RESP
    } state_t;

    localparam logic [2:0] RD_LAT_C = 3'(READ_LATENCY);
    localparam logic [8:0] TMO_C    = 9'(WAIT_TIMEOUT);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                read_q;
    logic                write_q;
    logic                tx_valid_q;
    logic                err_q;
    logic [7:0]          wait_cnt_q;
    logic [8:0]          wait_cnt_d;
    logic [2:0]          lat_cnt_q;
    logic                rx_fire;
    logic                op_write;
    logic                op_read;

    assign rx_ready_o = (state_q == S_IDLE || state_q == S_GET_DATA) && !rst_i;
    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign op_write   = (rx_data_i[7:6] == 2'b01) && (rx_data_i[5:4] == 2'b00);
    assign op_read    = (rx_data_i[7:6] == 2'b10) && (rx_data_i[5:4] == 2'b00);
    // Count including the current stalled cycle, so the limit hits in that cycle.
    assign wait_cnt_d = {1'b0, wait_cnt_q} + 9'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_data_q  <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_fire) begin
                        if (op_write) begin
                            addr_q  <= rx_data_i[ADDR_W-1:0];
                            state_q <= S_GET_DATA;
                        end else if (op_read) begin
                            addr_q     <= rx_data_i[ADDR_W-1:0];
                            read_q     <= 1'b1;
                            wait_cnt_q <= '0;
                            state_q    <= S_RD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_GET_DATA: begin
                    if (rx_fire) begin
                        wdata_q    <= rx_data_i;
                        write_q    <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= S_WR;
                    end
                end
                S_WR: begin
                    if (!avm_waitrequest_i) begin
                        write_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (wait_cnt_d == TMO_C) begin
                        write_q <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_d[7:0];
                    end
                end
                S_RD: begin
                    if (!avm_waitrequest_i) begin
                        read_q <= 1'b0;
                        if (RD_LAT_C == 3'd0) begin
                            tx_data_q  <= avm_readdata_i;
                            tx_valid_q <= 1'b1;
                            state_q    <= S_RESP;
                        end else begin
                            lat_cnt_q <= 3'd1;
                            state_q   <= S_RD_LAT;
                        end
                    end else if (wait_cnt_d == TMO_C) begin
                        read_q     <= 1'b0;
                        err_q      <= 1'b1;
                        tx_data_q  <= ERR_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_d[7:0];
                    end
                end
                S_RD_LAT: begin
                    if (lat_cnt_q == RD_LAT_C) begin
                        tx_data_q  <= avm_readdata_i;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                S_RESP: begin
                    if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign avm_address_o   = addr_q;
    assign avm_read_o      = read_q;
    assign avm_write_o     = write_q;
    assign avm_writedata_o = wdata_q;
    assign tx_data_o       = tx_data_q;
    assign tx_valid_o      = tx_valid_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_uart_mm_master.sv
// Bench for uart_mm_master: directed scenarios plus randomized command mix
// against a register-array reference model and a stalling Avalon slave.
module tb_uart_mm_master;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [3:0] avm_address;
    logic       avm_read, avm_write;
    logic [7:0] avm_writedata;
    logic [7:0] avm_readdata = 8'h00;
    logic       avm_waitreq = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       err;

    int n_cmp = 0;
    int n_mis = 0;

    uart_mm_master #(.ADDR_W(4), .DATA_W(8), .READ_LATENCY(1),
                     .WAIT_TIMEOUT(TMO), .ERR_BYTE(8'hEE)) dut (
        .clk_i(clk), .rst_i(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .avm_address_o(avm_address), .avm_read_o(avm_read), .avm_write_o(avm_write),
        .avm_writedata_o(avm_writedata), .avm_readdata_i(avm_readdata),
        .avm_waitrequest_i(avm_waitreq),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .err_o(err)
    );

    always #5 clk = ~clk;

    // Slave: stalls stall_cfg cycles per command, returns read data one cycle after accept.
    logic [7:0] smem [16];
    int         stall_cfg = 0, stall_left = 0;
    bit         in_cmd = 0, pend = 0;
    logic [7:0] pend_val, cmd_wdata;
    logic [3:0] cmd_addr;
    int         wr_cycles = 0, rd_cycles = 0, wr_acc = 0, rd_acc = 0, unstable = 0;
    logic [3:0] last_wr_addr, last_rd_addr;
    logic [7:0] last_wr_data;

    always begin
        @(posedge clk); #1;
        if (rst) begin
            in_cmd = 0; pend = 0; avm_waitreq = 1'b0;
        end else begin
            if (pend) begin avm_readdata = pend_val; pend = 0; end
            else avm_readdata = 8'($urandom);
            if (!(avm_read || avm_write)) begin
                in_cmd = 0; avm_waitreq = 1'b0;
            end else begin
                if (!in_cmd) begin
                    in_cmd = 1; stall_left = stall_cfg;
                    cmd_addr = avm_address; cmd_wdata = avm_writedata;
                end else if (avm_address !== cmd_addr ||
                             (avm_write && avm_writedata !== cmd_wdata)) begin
                    unstable++;
                end
                if (avm_write) wr_cycles++;
                if (avm_read) rd_cycles++;
                if (stall_left > 0) begin
                    avm_waitreq = 1'b1; stall_left--;
                end else begin
                    avm_waitreq = 1'b0; in_cmd = 0;
                    if (avm_write) begin
                        smem[avm_address] = avm_writedata; wr_acc++;
                        last_wr_addr = avm_address; last_wr_data = avm_writedata;
                    end else begin
                        pend = 1; pend_val = smem[avm_address];
                        avm_readdata = ~smem[avm_address];
                        rd_acc++; last_rd_addr = avm_address;
                    end
                end
            end
        end
    end

    int err_cnt = 0, tx_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (err) err_cnt++;
            if (tx_valid && tx_ready) tx_cnt++;
            if (avm_read && avm_write) both_cnt++;
        end
    end

    logic [7:0] ref_mem [16];
    logic [7:0] exp_q [$];

    function automatic bit is_legal(logic [7:0] b);
        return (b[7:6] == 2'b01 || b[7:6] == 2'b10) && b[5:4] == 2'b00;
    endfunction

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        rx_data = b; rx_valid = 1'b1; ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (rx_ready) begin step(); ok = 1; break; end
            step();
        end
        rx_valid = 1'b0;
    endtask

    task automatic get_tx(input int delay, output logic [7:0] data, output bit seen,
                          output bit stable);
        tx_ready = 1'b0; seen = 0; stable = 1; data = 8'h00;
        for (int k = 0; k < 60; k++) begin
            if (tx_valid) begin seen = 1; break; end
            step();
        end
        if (seen) begin
            data = tx_data;
            if (rx_ready) stable = 0;
            for (int d = 0; d < delay; d++) begin
                step();
                if (!tx_valid || tx_data !== data || rx_ready) stable = 0;
            end
            tx_ready = 1'b1; step(); tx_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; step(3);
        n_cmp++;
        if ({avm_read, avm_write, tx_valid, err, rx_ready} !== 5'b0) begin
            n_mis++; $display("FAIL reset_ctrl got=%b want=00000",
                              {avm_read, avm_write, tx_valid, err, rx_ready});
        end
        n_cmp++;
        if ({avm_address, avm_writedata, tx_data} !== 20'h0) begin
            n_mis++; $display("FAIL reset_data got=%h want=00000",
                              {avm_address, avm_writedata, tx_data});
        end
        rst = 1'b0; step();
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_mis++; $display("FAIL reset_release_ready got=%b want=1", rx_ready);
        end
    endtask

    task automatic test_write;
        bit ok0, ok1;
        int w0 = wr_cycles, a0 = wr_acc, t0 = tx_cnt, e0 = err_cnt;
        stall_cfg = 0;
        send_byte(8'h42, ok0); send_byte(8'hA5, ok1); step(6);
        n_cmp++;
        if (!(ok0 && ok1)) begin n_mis++; $display("FAIL write_rx_accept got=%0b%0b want=11", ok0, ok1); end
        n_cmp++;
        if (wr_cycles - w0 != 1 || wr_acc - a0 != 1) begin
            n_mis++; $display("FAIL write_cycles got=%0d/%0d want=1/1", wr_cycles - w0, wr_acc - a0);
        end
        n_cmp++;
        if (last_wr_addr !== 4'h2 || last_wr_data !== 8'hA5) begin
            n_mis++; $display("FAIL write_addr_data got=%h/%h want=2/a5", last_wr_addr, last_wr_data);
        end
        n_cmp++;
        if (tx_cnt != t0 || err_cnt != e0) begin
            n_mis++; $display("FAIL write_no_tx_err got=%0d/%0d want=0/0", tx_cnt - t0, err_cnt - e0);
        end
    endtask

    task automatic test_read(input int delay, input string name);
        bit ok, seen, stable;
        logic [7:0] d;
        int r0 = rd_cycles;
        stall_cfg = 0; smem[2] = 8'h3C;
        send_byte(8'h82, ok);
        get_tx(delay, d, seen, stable);
        n_cmp++;
        if (!ok || !seen || d !== 8'h3C) begin
            n_mis++; $display("FAIL %s_data got=%h seen=%0b want=3c", name, d, seen);
        end
        n_cmp++;
        if (rd_cycles - r0 != 1 || last_rd_addr !== 4'h2) begin
            n_mis++; $display("FAIL %s_bus got=%0d@%h want=1@2", name, rd_cycles - r0, last_rd_addr);
        end
        n_cmp++;
        if (!stable) begin n_mis++; $display("FAIL %s_hold got=unstable want=stable", name); end
        n_cmp++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            n_mis++; $display("FAIL %s_back_idle got=%b%b want=10", name, rx_ready, tx_valid);
        end
    endtask

    task automatic test_waitrequest;
        bit ok0, ok1;
        int w0 = wr_cycles, a0 = wr_acc, u0 = unstable;
        stall_cfg = 3;
        send_byte(8'h47, ok0); send_byte(8'h11, ok1); step(8);
        stall_cfg = 0;
        n_cmp++;
        if (wr_cycles - w0 != 4 || wr_acc - a0 != 1) begin
            n_mis++; $display("FAIL wait_write_cycles got=%0d/%0d want=4/1", wr_cycles - w0, wr_acc - a0);
        end
        n_cmp++;
        if (unstable != u0 || last_wr_addr !== 4'h7 || last_wr_data !== 8'h11) begin
            n_mis++; $display("FAIL wait_write_stable got=%0d %h/%h want=0 7/11",
                              unstable - u0, last_wr_addr, last_wr_data);
        end
    endtask

    task automatic test_timeout;
        bit ok, ok1, seen, stable;
        logic [7:0] d;
        int r0 = rd_cycles, ra = rd_acc, e0 = err_cnt, w0, wa, t0;
        stall_cfg = 255;
        send_byte(8'h85, ok);
        get_tx(0, d, seen, stable);
        n_cmp++;
        if (!seen || d !== 8'hEE) begin n_mis++; $display("FAIL tmo_read_byte got=%h want=ee", d); end
        n_cmp++;
        if (rd_cycles - r0 != TMO || rd_acc != ra || err_cnt - e0 != 1) begin
            n_mis++; $display("FAIL tmo_read_bus got=%0d/%0d/%0d want=%0d/0/1",
                              rd_cycles - r0, rd_acc - ra, err_cnt - e0, TMO);
        end
        w0 = wr_cycles; wa = wr_acc; e0 = err_cnt; t0 = tx_cnt;
        send_byte(8'h49, ok); send_byte(8'h77, ok1); step(8);
        n_cmp++;
        if (wr_cycles - w0 != TMO || wr_acc != wa || err_cnt - e0 != 1 || tx_cnt != t0) begin
            n_mis++; $display("FAIL tmo_write got=%0d/%0d/%0d/%0d want=%0d/0/1/0",
                              wr_cycles - w0, wr_acc - wa, err_cnt - e0, tx_cnt - t0, TMO);
        end
        stall_cfg = 0;
    endtask

    task automatic test_illegal;
        bit ok0, ok1, ok2, seen, stable;
        logic [7:0] d;
        int e0 = err_cnt, b0 = wr_cycles + rd_cycles;
        send_byte(8'hC1, ok0); send_byte(8'h51, ok1); step(3);
        n_cmp++;
        if (err_cnt - e0 != 2 || wr_cycles + rd_cycles != b0) begin
            n_mis++; $display("FAIL illegal_err got=%0d/%0d want=2/0", err_cnt - e0, wr_cycles + rd_cycles - b0);
        end
        smem[3] = 8'h6B;
        send_byte(8'h83, ok2); get_tx(1, d, seen, stable);
        n_cmp++;
        if (!(ok0 && ok1 && ok2) || !seen || d !== 8'h6B) begin
            n_mis++; $display("FAIL illegal_then_read got=%h want=6b", d);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int t0;
        smem[2] = 8'h3C; stall_cfg = 0; tx_ready = 1'b1;
        send_byte(8'h82, ok); step();
        n_cmp++;
        if (avm_read !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
            n_mis++; $display("FAIL rstmid_in_lat got=%b%b%b want=000", avm_read, tx_valid, rx_ready);
        end
        t0 = tx_cnt;
        rst = 1'b1; step();
        n_cmp++;
        if ({avm_read, avm_write, tx_valid, err, rx_ready} !== 5'b0 || tx_data !== 8'h00) begin
            n_mis++; $display("FAIL rstmid_outputs got=%b %h want=00000 00",
                              {avm_read, avm_write, tx_valid, err, rx_ready}, tx_data);
        end
        rst = 1'b0; step();
        n_cmp++;
        if (rx_ready !== 1'b1) begin n_mis++; $display("FAIL rstmid_ready got=%b want=1", rx_ready); end
        step(5);
        n_cmp++;
        if (tx_cnt != t0) begin n_mis++; $display("FAIL rstmid_no_tx got=%0d want=0", tx_cnt - t0); end
        tx_ready = 1'b0;
    endtask

    task automatic test_random;
        bit ok, ok1, seen, stable;
        logic [7:0] b, d, v, want;
        logic [3:0] a;
        int kind, stall, exp_err = err_cnt;
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom); smem[i] = v; ref_mem[i] = v;
        end
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            stall = $urandom_range(0, 5);
            stall_cfg = stall;
            a = 4'($urandom);
            if (kind < 4) begin
                d = 8'($urandom);
                send_byte({4'b0100, a}, ok); send_byte(d, ok1); step(8);
                if (stall < TMO) ref_mem[a] = d;
                else exp_err++;
            end else if (kind < 8) begin
                want = (stall < TMO) ? ref_mem[a] : 8'hEE;
                if (stall >= TMO) exp_err++;
                exp_q.push_back(want);
                send_byte({4'b1000, a}, ok);
                get_tx($urandom_range(0, 3), d, seen, stable);
                want = exp_q.pop_front();
                n_cmp++;
                if (!seen || d !== want || !stable) begin
                    n_mis++; $display("FAIL rand_read[%0d] addr=%h got=%h want=%h seen=%0b stable=%0b",
                                      n, a, d, want, seen, stable);
                end
            end else begin
                do b = 8'($urandom); while (is_legal(b));
                send_byte(b, ok); step(2);
                exp_err++;
            end
            n_cmp++;
            if (err_cnt != exp_err) begin
                n_mis++; $display("FAIL rand_err[%0d] got=%0d want=%0d", n, err_cnt, exp_err);
            end
        end
        stall_cfg = 0;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (smem[i] !== ref_mem[i]) begin
                n_mis++; $display("FAIL rand_mem[%0d] got=%h want=%h", i, smem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(0, "read");
        test_read(5, "backpressure");
        test_waitrequest();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_random();
        n_cmp++;
        if (both_cnt != 0) begin n_mis++; $display("FAIL rd_wr_overlap got=%0d want=0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "time limit");
    end

endmodule
